// File: rtl/exec_writeback_unit_if.sv
// Execute-stage handshake: operand/opcode request from control and RegisterFile,
// writeback pulse and status returned by the execute unit.
interface exec_writeback_unit_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] dest_addr;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic              done;
  logic              wb_enable;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              zero_flag;
  logic              carry_flag;
  logic              illegal_op;

  modport master (
    output start, opcode, dest_addr, operand_a, operand_b,
    input  busy, done, wb_enable, wb_addr, wb_data, zero_flag, carry_flag, illegal_op
  );

  modport slave (
    input  start, opcode, dest_addr, operand_a, operand_b,
    output busy, done, wb_enable, wb_addr, wb_data, zero_flag, carry_flag, illegal_op
  );
endinterface

// File: rtl/exec_writeback_unit.sv
// Execute stage: single-cycle ALU ops or 18-cycle shift-add multiply, followed by
// a one-cycle RegisterFile writeback pulse.
module exec_writeback_unit #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  exec_writeback_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [3:0] {
    OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3, OpXor = 4'd4,
    OpNot = 4'd5, OpShl = 4'd6, OpShr = 4'd7, OpPassB = 4'd8, OpMul = 4'd9
  } op_e;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d, mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                busy_q, busy_d, done_q, done_d, wb_en_q, wb_en_d;
  logic                illegal_q, illegal_d, zero_q, zero_d, carry_q, carry_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;

  logic [DATA_W:0]     alu_sum;
  logic [DATA_W-1:0]   alu_res, fin_res;
  logic                alu_carry, fin_carry, fin;

  always_comb begin
    alu_sum   = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OpAdd: begin
        alu_sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OpSub: begin
        // Bit DATA_W of the widened difference is the borrow (a < b).
        alu_sum   = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = alu_sum[DATA_W-1:0];
        alu_carry = alu_sum[DATA_W];
      end
      OpAnd:   alu_res = a_q & b_q;
      OpOr:    alu_res = a_q | b_q;
      OpXor:   alu_res = a_q ^ b_q;
      OpNot:   alu_res = ~a_q;
      OpShl: begin
        alu_res   = {a_q[DATA_W-2:0], 1'b0};
        alu_carry = a_q[DATA_W-1];
      end
      OpShr: begin
        alu_res   = {1'b0, a_q[DATA_W-1:1]};
        alu_carry = a_q[0];
      end
      OpPassB: alu_res = b_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dest_d    = dest_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    illegal_d = 1'b0;
    zero_d    = zero_q;
    carry_d   = carry_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    fin       = 1'b0;
    fin_res   = alu_res;
    fin_carry = alu_carry;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d     = bus.opcode;
          dest_d   = bus.dest_addr;
          a_d      = bus.operand_a;
          b_d      = bus.operand_b;
          busy_d   = 1'b1;
          cnt_d    = '0;
          prod_d   = '0;
          mcand_d  = {{DATA_W{1'b0}}, bus.operand_a};
          mplier_d = bus.operand_b;
          state_d  = (bus.opcode == OpMul) ? StMul : StExec;
        end
      end
      StExec: begin
        fin     = 1'b1;
        state_d = StWb;
      end
      StMul: begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          fin       = 1'b1;
          fin_res   = prod_d[DATA_W-1:0];
          fin_carry = |prod_d[2*DATA_W-1:DATA_W];
          cnt_d     = '0;
          state_d   = StWb;
        end
      end
      StWb: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered on the edge entering WB so they are valid for the WB cycle.
    if (fin) begin
      done_d = 1'b1;
      if (op_q <= OpMul) begin
        wb_en_d   = 1'b1;
        wb_addr_d = dest_q;
        wb_data_d = fin_res;
        zero_d    = (fin_res == '0);
        carry_d   = fin_carry;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wb_enable  = wb_en_q;
  assign bus.wb_addr    = wb_addr_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.zero_flag  = zero_q;
  assign bus.carry_flag = carry_q;
  assign bus.illegal_op = illegal_q;
endmodule

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
- Execute stage directly downstream of RegisterFile.
- Takes the two 18-bit read operands plus an opcode and destination register.
- Computes the result: single-cycle ALU ops, or an iterative 18-cycle shift-add multiply.
- Drives RegisterFile write_addr/write_data/write_enable with a one-cycle writeback pulse; busy/done handshake to the control unit.

Parameters:
- DATA_W, 18, operand/result width (matches RegisterFile word).
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- opcode  input  4  operation select, captured on accept.
- dest_addr  input  ADDR_W  destination register, captured on accept.
- operand_a  input  DATA_W  from RegisterFile data_out1, captured on accept.
- operand_b  input  DATA_W  from RegisterFile data_out2, captured on accept.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in WB.
- wb_enable  output  1  to RegisterFile write_enable; one-cycle pulse in WB for legal opcodes.
- wb_addr  output  ADDR_W  to RegisterFile write_addr.
- wb_data  output  DATA_W  to RegisterFile write_data.
- zero_flag  output  1  result == 0 at last legal WB.
- carry_flag  output  1  carry/borrow at last legal WB.
- illegal_op  output  1  one-cycle pulse in WB for undefined opcode.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, done, wb_enable, illegal_op, zero_flag, carry_flag = 0; wb_addr=0, wb_data=0; mul counter=0. Reset overrides everything, including mid-MUL or in WB: no writeback issued.
- States: IDLE, EXEC, MUL, WB.
- IDLE: on start=1, capture opcode/dest_addr/operand_a/operand_b. Next state is MUL if opcode=MUL, otherwise EXEC.
- start while busy=1: ignored; captured values held stable.
- Opcodes:
  - 0 ADD: a+b; carry = bit 18 of the 19-bit sum.
  - 1 SUB: a-b mod 2^18; carry = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: a<<1; carry = a[17].
  - 7 SHR: logical a>>1; carry = a[0].
  - 8 PASSB: result = b (load/move).
  - 9 MUL: low 18 bits of a*b; carry = 1 if the high product bits are nonzero.
  - 10–15: illegal.
- carry=0 for ops that do not define it.
- EXEC: one cycle; result registered into wb_data, wb_addr <= dest; next state WB.
- MUL: iterative shift-add, one multiplier bit per cycle, LSB first. Counter runs 0..17. When counter=17, next state is WB. MUL occupies exactly 18 cycles.
- WB: one cycle. done=1. For a legal op: wb_enable=1, zero_flag/carry_flag updated. For an illegal op: wb_enable=0, illegal_op=1, flags unchanged. Next state IDLE.
- Latency, edges counted from the edge that accepts start (edge k):
  - ALU ops: WB outputs valid in the cycle after edge k+1.
  - MUL: WB outputs valid in the cycle after edge k+18.
  - A back-to-back start is accepted at the edge ending WB+1, i.e. the first IDLE cycle.
- wb_addr/wb_data hold their last values outside WB. Only wb_enable qualifies them.
- Flags hold between writebacks.
- Arithmetic is unsigned, modulo 2^18. No saturation.
- dest_addr 0 is written like any other register.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0; busy=0; no wb_enable pulse for 10 cycles.
- ADD: start, opcode=0, a=18'd42, b=18'hA5, dest=3 → exactly one wb_enable pulse 2 edges after accept; wb_addr=3, wb_data=207; carry=0, zero=0. A RegisterFile readback of r3 returns 207.
- Carry/zero: ADD a=18'h3FFFF, b=1 → wb_data=0, carry=1, zero=1. SUB a=5, b=7 → wb_data=18'h3FFFE, carry=1.
- MUL: a=300, b=700, dest=1 → busy high for 19 cycles; WB after edge k+18; wb_data=210000 mod 262144=210000, carry=0. Then a=1024, b=1024 → wb_data=0, carry=1, zero=1.
- Busy/illegal: assert start again during MUL with different operands → ignored, result unchanged. opcode=12 → done=1, illegal_op=1, wb_enable=0, flags unchanged.
- Reset mid-op: rst=1 at MUL iteration 9 → IDLE next cycle; no wb_enable pulse; a new ADD afterwards completes normally.
